chunk_streamer: RTL and testbench
=================================

CHUNK_STREAMER -- requirements
Module: chunk_streamer

Interface
REQ-001 Parameter SAMPLE_SIZE, default 24: sample width in bits.
REQ-002 Parameter IO_BUFF_SIZE, default 64: samples per chunk, which is also the depth of both buffers.
REQ-003 Parameter IO_BUFF_PTR_BITS, default $clog2(IO_BUFF_SIZE): buffer pointer width.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; 0 means reset.
REQ-006 in_sample_valid  in  1  one-cycle strobe marking a new audio sample.
REQ-007 in_sample  in  SAMPLE_SIZE  audio sample, qualified by in_sample_valid.
REQ-008 input_buff_wr_ptr  out  IO_BUFF_PTR_BITS  input-buffer write address.
REQ-009 input_buff_wr_data  out  SAMPLE_SIZE  input-buffer write data.
REQ-010 input_buff_wr_en  out  1  input-buffer write strobe.
REQ-011 output_buff_rd_ptr  out  IO_BUFF_PTR_BITS  output-buffer read address.
REQ-012 output_buff_rd_sample  in  SAMPLE_SIZE  output-buffer read data; synchronous RAM with 1-cycle read latency.
REQ-013 chunk_pulse  out  1  one-cycle pulse when a full chunk has been written; drives the processor's chunk_pulse.
REQ-014 out_sample  out  SAMPLE_SIZE  processed sample streamed out.
REQ-015 out_sample_valid  out  1  one-cycle strobe qualifying out_sample.
REQ-016 overrun  out  1  sticky flag; set when an input sample was dropped.
REQ-017 chunk_count  out  16  count of completed chunks; wraps modulo 2^16.

Function
REQ-018 The block SHALL implement FSM states S_IDLE, S_WR and S_RD, encoded in 2 bits; any illegal encoding SHALL return to S_IDLE.
REQ-019 A single pointer ptr SHALL drive both input_buff_wr_ptr and output_buff_rd_ptr at all times.
REQ-020 In S_IDLE with in_sample_valid=1 (cycle T), the block SHALL capture in_sample into a register and go to S_WR.
REQ-021 In S_WR (cycle T+1), the block SHALL:
- assert input_buff_wr_en=1 for exactly that cycle;
- drive input_buff_wr_data with the captured sample, written at address ptr;
- go to S_RD.
REQ-022 In S_RD (cycle T+2), the block SHALL register output_buff_rd_sample into out_sample and go to S_IDLE.
REQ-023 At the end of S_RD, if ptr < IO_BUFF_SIZE-1, ptr SHALL increment by 1.
REQ-024 At the end of S_RD, if ptr == IO_BUFF_SIZE-1, the block SHALL:
- set ptr to 0;
- assert chunk_pulse for one cycle (T+3);
- set primed to 1;
- increment chunk_count.
REQ-025 out_sample_valid SHALL pulse in cycle T+3 only if primed was 1 before that S_RD cycle, so no output is produced during the first chunk after reset.
REQ-026 Latency from in_sample_valid to the matching out_sample_valid SHALL be exactly 3 cycles.
- The output sample comes from the same index ptr of the previously processed chunk.
- The processor SHALL finish each chunk within IO_BUFF_SIZE sample periods; this is a system constraint and is not checked by this block.
REQ-027 Minimum accepted input spacing SHALL be 3 cycles.
- in_sample_valid asserted in S_WR or S_RD SHALL be dropped: no write and no pointer change.
- overrun SHALL be set and held until reset.
REQ-028 When in_sample_valid coincides with the S_RD to S_IDLE transition, it SHALL be dropped, because acceptance occurs only while in S_IDLE.
REQ-029 chunk_pulse and out_sample_valid SHALL both assert in the same cycle (T+3) for the sample at index IO_BUFF_SIZE-1.
REQ-030 chunk_count SHALL wrap from 16'hFFFF to 0 with no other side effect.
REQ-031 All outputs SHALL be registered, except input_buff_wr_en, which is decoded from state == S_WR.

Reset
REQ-032 While rst=0 at a clock edge, the block SHALL reset:
- state to S_IDLE;
- ptr, primed and overrun to 0;
- chunk_count to 0;
- out_sample and the captured sample register to 0;
- out_sample_valid and chunk_pulse to 0.
REQ-033 Reset asserted in S_WR or S_RD SHALL abort the transaction: no write-enable after reset, no pointer advance, no output strobe.
REQ-034 The first sample accepted after reset release SHALL be written at address 0.

Verification
REQ-035 Bench SHALL cover: after reset, 64 samples 0x000001..0x000040 at 4-cycle spacing -> writes at ptr 0..63, out_sample_valid never asserted, one chunk_pulse 3 cycles after the 64th strobe, chunk_count=1.
REQ-036 Bench SHALL cover: output RAM preloaded with ptr*0x10, second chunk streamed -> out_sample sequence 0x000, 0x010, ..., 0x3F0, each exactly 3 cycles after its input strobe.
REQ-037 Bench SHALL cover: strobes at cycles T and T+1 -> one write only, ptr advances by 1, overrun=1 and stays 1 until rst=0.
REQ-038 Bench SHALL cover: rst=0 in the cycle the FSM is in S_WR -> no further wr_en, ptr=0, and the next sample is written at address 0.
REQ-039 Bench SHALL cover: chunk_count forced near wrap via 65536 chunks (accelerated with IO_BUFF_SIZE=4) -> chunk_count returns to 0 and chunk_pulse continues normally.

Source files
------------

// File: rtl/chunk_streamer.sv
// chunk_streamer: writes audio samples into a chunk buffer and streams the
// processed samples back out of the previous chunk at the same index.
module chunk_streamer #(
   parameter int SAMPLE_SIZE      = 24,
   parameter int IO_BUFF_SIZE     = 64,
   parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_sample_valid,
   input  logic [SAMPLE_SIZE-1:0]      in_sample,
   output logic [IO_BUFF_PTR_BITS-1:0] input_buff_wr_ptr,
   output logic [SAMPLE_SIZE-1:0]      input_buff_wr_data,
   output logic                        input_buff_wr_en,
   output logic [IO_BUFF_PTR_BITS-1:0] output_buff_rd_ptr,
   input  logic [SAMPLE_SIZE-1:0]      output_buff_rd_sample,
   output logic                        chunk_pulse,
   output logic [SAMPLE_SIZE-1:0]      out_sample,
   output logic                        out_sample_valid,
   output logic                        overrun,
   output logic [15:0]                 chunk_count
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd2} state_t;
   localparam logic [IO_BUFF_PTR_BITS-1:0] LAST = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
   state_t                      state, state_nxt;
   logic [IO_BUFF_PTR_BITS-1:0] ptr;
   logic [SAMPLE_SIZE-1:0]      sample_q;
   logic                        primed;
   logic                        accept, busy, wrap;
   assign accept             = (state == S_IDLE) && in_sample_valid;
   assign busy               = (state == S_WR) || (state == S_RD);
   assign wrap               = ptr == LAST;
   assign input_buff_wr_ptr  = ptr;
   assign output_buff_rd_ptr = ptr;
   assign input_buff_wr_data = sample_q;
   assign input_buff_wr_en   = state == S_WR;
   // state register; reset always lands in idle
   always_ff @(posedge clk) state <= !rst ? S_IDLE : state_nxt;
   // next state: accept only in idle, then one write cycle and one read cycle; illegal codes fall to idle
   always_comb begin
      state_nxt = S_IDLE;
      state_nxt = accept ? S_WR : (state == S_WR) ? S_RD : S_IDLE;
   end
   // datapath: sample capture, output register, pointer/chunk bookkeeping and overrun flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr              <= '0;
         sample_q         <= '0;
         primed           <= 1'b0;
         overrun          <= 1'b0;
         chunk_count      <= 16'd0;
         out_sample       <= '0;
         out_sample_valid <= 1'b0;
         chunk_pulse      <= 1'b0;
      end else begin
         if (accept) sample_q <= in_sample;
         if (in_sample_valid && busy) overrun <= 1'b1;
         out_sample_valid <= (state == S_RD) && primed;
         chunk_pulse      <= (state == S_RD) && wrap;
         if (state == S_RD) begin
            out_sample <= output_buff_rd_sample;
            ptr        <= wrap ? '0 : ptr + 1'b1;
            if (wrap) begin
               primed      <= 1'b1;
               chunk_count <= chunk_count + 16'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_chunk_streamer.sv
// tb_chunk_streamer: scoreboard and table-driven bench for chunk_streamer
module tb_chunk_streamer;
   localparam int N = 64;
   typedef struct {int c; int ptr; logic [23:0] d;} ev_t;
   typedef struct {logic [23:0] din; int gap; int exp_ptr; logic [23:0] exp_out;} vec_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, in_valid, wr_en, chunk_pulse, out_valid, overrun;
   logic [23:0] in_sample, wr_data, rd_sample, out_sample;
   logic [5:0]  wr_ptr, rd_ptr;
   logic [15:0] chunk_count;
   logic        rst4, v4, we4, cp4, ovl4, ovr4;
   logic [1:0]  wp4, rp4;
   logic [23:0] wd4, os4;
   logic [15:0] cc4;
   int tests = 0, fails = 0, cyc = 0, p4 = 0;
   int mptr = 0, mcount = 0;
   bit mprimed = 0;
   logic [23:0] omem [N];
   ev_t wq[$], oq[$];
   int  pq[$];
   vec_t tbl [8];

   chunk_streamer dut (
      .clk(clk), .rst(rst), .in_sample_valid(in_valid), .in_sample(in_sample),
      .input_buff_wr_ptr(wr_ptr), .input_buff_wr_data(wr_data), .input_buff_wr_en(wr_en),
      .output_buff_rd_ptr(rd_ptr), .output_buff_rd_sample(rd_sample),
      .chunk_pulse(chunk_pulse), .out_sample(out_sample), .out_sample_valid(out_valid),
      .overrun(overrun), .chunk_count(chunk_count));

   chunk_streamer #(.SAMPLE_SIZE(24), .IO_BUFF_SIZE(4)) dut4 (
      .clk(clk), .rst(rst4), .in_sample_valid(v4), .in_sample(24'h5A5A5A),
      .input_buff_wr_ptr(wp4), .input_buff_wr_data(wd4), .input_buff_wr_en(we4),
      .output_buff_rd_ptr(rp4), .output_buff_rd_sample(24'h000000),
      .chunk_pulse(cp4), .out_sample(os4), .out_sample_valid(ovl4),
      .overrun(ovr4), .chunk_count(cc4));

   // cycle counter and output RAM with one-cycle read latency
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      rd_sample <= omem[rd_ptr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // scoreboard monitor: every strobe must match the oldest expected event
   always @(negedge clk) begin : mon
      ev_t e;
      if (wr_en) begin
         if (wq.size() == 0) chk("unexpected write", wr_en, 0);
         else begin
            e = wq.pop_front();
            chk("write cycle", cyc, e.c);
            chk("write ptr", wr_ptr, e.ptr);
            chk("write data", wr_data, e.d);
         end
      end
      if (out_valid) begin
         if (oq.size() == 0) chk("unexpected out_valid", out_valid, 0);
         else begin
            e = oq.pop_front();
            chk("out cycle", cyc, e.c);
            chk("out data", out_sample, e.d);
         end
      end
      if (chunk_pulse) begin
         if (pq.size() == 0) chk("unexpected chunk_pulse", chunk_pulse, 0);
         else chk("pulse cycle", cyc, pq.pop_front());
      end
      if (cp4) p4++;
   end

   task automatic push(input logic [23:0] d);
      ev_t e;
      e.c = cyc + 1; e.ptr = mptr; e.d = d;
      wq.push_back(e);
      if (mprimed) begin
         e.c = cyc + 3; e.d = omem[mptr];
         oq.push_back(e);
      end
      if (mptr == N - 1) begin
         pq.push_back(cyc + 3);
         mprimed = 1; mcount++; mptr = 0;
      end else mptr++;
   endtask

   task automatic send(input logic [23:0] d, input int gap);
      in_valid = 1'b1; in_sample = d;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   initial begin
      ev_t e;
      logic [23:0] d;
      tbl[0] = '{24'hABCDEF, 3, 0, 24'h000000};
      tbl[1] = '{24'h000000, 5, 1, 24'h000010};
      tbl[2] = '{24'hFFFFFF, 3, 2, 24'h000020};
      tbl[3] = '{24'h800001, 8, 3, 24'h000030};
      tbl[4] = '{24'h7FFFFE, 3, 4, 24'h000040};
      tbl[5] = '{24'h123456, 4, 5, 24'h000050};
      tbl[6] = '{24'hA5A5A5, 3, 6, 24'h000060};
      tbl[7] = '{24'h5A5A5A, 6, 7, 24'h000070};
      for (int i = 0; i < N; i++) omem[i] = 24'(i * 16);
      rst = 1'b0; rst4 = 1'b0; in_valid = 1'b0; in_sample = '0; v4 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst wr_ptr", wr_ptr, 0);
      chk("rst rd_ptr", rd_ptr, 0);
      chk("rst wr_en", wr_en, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst chunk_pulse", chunk_pulse, 0);
      chk("rst overrun", overrun, 0);
      chk("rst chunk_count", chunk_count, 0);
      chk("rst out_sample", out_sample, 0);
      chk("rst wr_data", wr_data, 0);
      rst = 1'b1; rst4 = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         push(24'(i + 1));
         send(24'(i + 1), 4);
      end
      @(negedge clk);
      chk("chunk1 count", chunk_count, 1);
      chk("chunk1 pending", wq.size() + oq.size() + pq.size(), 0);
      for (int i = 0; i < N; i++) begin
         d = 24'($urandom());
         push(d);
         send(d, (i % 2) ? 4 : 3);
      end
      @(negedge clk);
      chk("chunk2 count", chunk_count, 2);
      chk("chunk2 pending", wq.size() + oq.size() + pq.size(), 0);
      for (int i = 0; i < 8; i++) begin
         chk("tbl ptr", wr_ptr, tbl[i].exp_ptr);
         e.c = cyc + 1; e.ptr = tbl[i].exp_ptr; e.d = tbl[i].din;
         wq.push_back(e);
         e.c = cyc + 3; e.d = tbl[i].exp_out;
         oq.push_back(e);
         mptr = tbl[i].exp_ptr + 1;
         send(tbl[i].din, tbl[i].gap);
      end
      chk("overrun clear", overrun, 0);
      push(24'h111111);
      in_valid = 1'b1; in_sample = 24'h111111;
      @(negedge clk);
      in_sample = 24'h222222;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("overrun set", overrun, 1);
      chk("ptr after drop", wr_ptr, 9);
      push(24'h333333);
      in_valid = 1'b1; in_sample = 24'h333333;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_sample = 24'h444444;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("ptr after rd drop", wr_ptr, 10);
      push(24'h555555);
      send(24'h555555, 5);
      chk("overrun sticky", overrun, 1);
      e.c = cyc + 1; e.ptr = mptr; e.d = 24'h666666;
      wq.push_back(e);
      in_valid = 1'b1; in_sample = 24'h666666;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("abort ptr", wr_ptr, 0);
      chk("abort overrun", overrun, 0);
      chk("abort chunk_count", chunk_count, 0);
      mptr = 0; mprimed = 0; mcount = 0;
      repeat (3) @(negedge clk);
      push(24'h777777);
      send(24'h777777, 4);
      @(negedge clk);
      chk("post-abort ptr", wr_ptr, 1);
      chk("post-abort pending", wq.size() + oq.size() + pq.size(), 0);
      for (int k = 0; k < 65536; k++) begin
         if (k == 65535) chk("wrap pre count", cc4, 16'hFFFF);
         for (int j = 0; j < 4; j++) begin
            v4 = 1'b1;
            @(negedge clk);
            v4 = 1'b0;
            repeat (2) @(negedge clk);
         end
      end
      @(negedge clk);
      chk("wrap count", cc4, 0);
      chk("wrap pulses", p4, 65536);
      for (int j = 0; j < 4; j++) begin
         v4 = 1'b1;
         @(negedge clk);
         v4 = 1'b0;
         repeat (3) @(negedge clk);
      end
      chk("post-wrap count", cc4, 1);
      chk("post-wrap pulses", p4, 65537);
      chk("wrap overrun", ovr4, 0);
      chk("final pending", wq.size() + oq.size() + pq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
